mfc_top: RTL and testbench

- Multi-function digital clock top level for the FPGA board.
- Contains a time-of-day clock, clock-set mode, alarm-set mode with alarm ringing, and a stopwatch.
- Inputs are slide switches (SPDT) and five push buttons; outputs drive an 8-digit multiplexed seven-segment display, LEDs and a piezo.
- All logic runs in the single MCLK (100 MHz) domain.

---
 rtl/mfc_pkg.sv | 78 +++++++
 rtl/mfc_btn_conditioner.sv | 48 ++++
 rtl/mfc_top.sv | 226 ++++++++++++++++++++++
 tb/tb_mfc_top.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mfc_pkg.sv
// Shared types and helpers for the multi-function clock: modes, cursor fields,
// button indices, time record arithmetic and seven-segment decoding.
package mfc_pkg;

    typedef enum logic [1:0] {NORMAL, CLK_SET, ALM_SET, STOPWATCH} mode_e;
    typedef enum logic [1:0] {F_SEC = 2'd0, F_MIN = 2'd1, F_HR = 2'd2} field_e;

    localparam int BTN_UP    = 0;
    localparam int BTN_DN    = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_SS    = 4;

    localparam logic [3:0] DIGIT_BLANK = 4'hF;

    typedef struct packed {
        logic [4:0] hr;
        logic [5:0] mn;
        logic [5:0] sc;
    } hms_t;

    // Active-high segments, bit 0 = a ... bit 6 = g; anything but 0-9 is blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [5:0] step_mod(input logic [5:0] v, input logic [5:0] top,
                                            input logic up, input logic dn);
        logic [5:0] r;
        r = v;
        if (up)      r = (v == top) ? 6'd0 : v + 6'd1;
        else if (dn) r = (v == 6'd0) ? top : v - 6'd1;
        return r;
    endfunction

    // Field edit without carry into neighbouring fields.
    function automatic hms_t hms_edit(input hms_t t, input field_e f,
                                      input logic up, input logic dn);
        hms_t r;
        r = t;
        case (f)
            F_SEC:   r.sc = step_mod(t.sc, 6'd59, up, dn);
            F_MIN:   r.mn = step_mod(t.mn, 6'd59, up, dn);
            default: r.hr = 5'(step_mod({1'b0, t.hr}, 6'd23, up, dn));
        endcase
        return r;
    endfunction

    function automatic hms_t hms_inc(input hms_t t);
        hms_t r;
        r = t;
        if (t.sc != 6'd59) begin
            r.sc = t.sc + 6'd1;
        end else begin
            r.sc = 6'd0;
            if (t.mn != 6'd59) begin
                r.mn = t.mn + 6'd1;
            end else begin
                r.mn = 6'd0;
                r.hr = (t.hr == 5'd23) ? 5'd0 : t.hr + 5'd1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mfc_btn_conditioner.sv
// Push-button front end: 2-FF synchronizer, stability debounce, and a single
// one-cycle pulse on each accepted press (no auto-repeat).
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic          meta_q, meta_d, sync_q, sync_d;
    logic          level_q, level_d, pulse_q, pulse_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // The counter only advances on consecutive disagreeing cycles, so any glitch resets it.
    always_comb begin
        meta_d  = raw;
        sync_d  = meta_q;
        level_d = level_q;
        cnt_d   = '0;
        if (sync_q != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) level_d = sync_q;
            else                                   cnt_d   = cnt_q + CW'(1);
        end
        pulse_d = level_d & ~level_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            meta_q  <= meta_d;
            sync_q  <= sync_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/mfc_top.sv
// Multi-function clock: time of day, clock/alarm set, alarm tone and stopwatch,
// shown on an 8-digit multiplexed seven-segment display.
module mfc_top
    import mfc_pkg::*;
#(
    parameter int TICKS_PER_SEC   = 100_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REFRESH_CYCLES  = 100_000,
    parameter int TONE_DIV        = 50_000
) (
    input  logic        MCLK,
    input  logic [14:0] SPDT,
    input  logic [4:0]  button,
    output logic [7:0]  seg_n,
    output logic [7:0]  an_n,
    output logic [15:0] led,
    output logic        piezo
);
    localparam int CS_DIV = TICKS_PER_SEC / 100;
    localparam int PW     = $clog2(TICKS_PER_SEC);
    localparam int SW     = $clog2(CS_DIV);
    localparam int RW     = $clog2(REFRESH_CYCLES);
    localparam int TW     = $clog2(TONE_DIV);

    logic rst, alm_en, unused_spdt;
    assign rst         = SPDT[0];
    assign alm_en      = SPDT[1];
    assign unused_spdt = ^SPDT[11:2];

    logic [4:0] btn_p;
    for (genvar i = 0; i < 5; i++) begin : g_btn
        btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
            .clk(MCLK), .rst(rst), .raw(button[i]), .pulse(btn_p[i])
        );
    end

    mode_e mode_q, mode_d;
    logic  in_clk, in_alm, in_sw;

    always_comb begin
        if (SPDT[14])      mode_d = CLK_SET;
        else if (SPDT[13]) mode_d = ALM_SET;
        else if (SPDT[12]) mode_d = STOPWATCH;
        else               mode_d = NORMAL;
    end

    always_comb begin
        in_clk = (mode_q == CLK_SET);
        in_alm = (mode_q == ALM_SET);
        in_sw  = (mode_q == STOPWATCH);
    end

    logic [PW-1:0] pre_q, pre_d;
    logic          sec_tick, cs_tick;
    hms_t          tm_q, tm_d, al_q, al_d;
    field_e        cur_q, cur_d;
    logic          ring_q, ring_d, piezo_q, piezo_d;
    logic [5:0]    rsec_q, rsec_d;
    logic [TW-1:0] tone_q, tone_d;
    logic          sw_run_q, sw_run_d;
    logic [SW-1:0] swp_q, swp_d;
    logic [6:0]    cs_q, cs_d;
    logic [5:0]    ss_q, ss_d, mm_q, mm_d;
    logic [RW-1:0] rf_q, rf_d;
    logic [2:0]    dig_q, dig_d;
    logic [7:0]    seg_q, seg_d, an_q, an_d;
    logic [6:0]    p2, p1, p0;
    logic [3:0]    digit;

    // Time is frozen in clock_set, so its own edits never race a tick.
    always_comb begin
        sec_tick = !in_clk && (pre_q == PW'(TICKS_PER_SEC - 1));
        pre_d    = (in_clk || sec_tick) ? '0 : pre_q + PW'(1);
        tm_d     = sec_tick ? hms_inc(tm_q) : tm_q;
        if (in_clk) tm_d = hms_edit(tm_q, cur_q, btn_p[BTN_UP], btn_p[BTN_DN]);
        al_d = in_alm ? hms_edit(al_q, cur_q, btn_p[BTN_UP], btn_p[BTN_DN]) : al_q;
        cur_d = cur_q;
        if (in_clk || in_alm) begin
            if (btn_p[BTN_LEFT]) begin
                case (cur_q)
                    F_SEC:   cur_d = F_MIN;
                    F_MIN:   cur_d = F_HR;
                    default: cur_d = F_SEC;
                endcase
            end else if (btn_p[BTN_RIGHT]) begin
                case (cur_q)
                    F_HR:    cur_d = F_MIN;
                    F_MIN:   cur_d = F_SEC;
                    default: cur_d = F_HR;
                endcase
            end
        end
    end

    always_comb begin
        ring_d = ring_q;
        rsec_d = rsec_q;
        if (ring_q) begin
            if (sec_tick) rsec_d = rsec_q + 6'd1;
            if (btn_p[BTN_SS] || !alm_en || (sec_tick && rsec_q == 6'd59)) ring_d = 1'b0;
        end
        if (sec_tick && alm_en && tm_d == al_d) begin
            ring_d = 1'b1;
            rsec_d = '0;
        end
        tone_d  = '0;
        piezo_d = 1'b0;
        if (ring_q) begin
            piezo_d = piezo_q;
            if (tone_q == TW'(TONE_DIV - 1)) piezo_d = !piezo_q;
            else                             tone_d  = tone_q + TW'(1);
        end
    end

    // The centisecond prescaler restarts from zero on every start.
    always_comb begin
        cs_tick  = sw_run_q && (swp_q == SW'(CS_DIV - 1));
        swp_d    = (sw_run_q && !cs_tick) ? swp_q + SW'(1) : '0;
        sw_run_d = sw_run_q;
        cs_d     = cs_q;
        ss_d     = ss_q;
        mm_d     = mm_q;
        if (cs_tick && !(mm_q == 6'd59 && ss_q == 6'd59 && cs_q == 7'd99)) begin
            if (cs_q != 7'd99) begin
                cs_d = cs_q + 7'd1;
            end else begin
                cs_d = '0;
                if (ss_q != 6'd59) begin
                    ss_d = ss_q + 6'd1;
                end else begin
                    ss_d = '0;
                    mm_d = mm_q + 6'd1;
                end
            end
        end
        if (in_sw) begin
            if (btn_p[BTN_SS]) sw_run_d = !sw_run_q;
            if (btn_p[BTN_DN] && !sw_run_q) begin
                cs_d = '0;
                ss_d = '0;
                mm_d = '0;
            end
        end
    end

    always_comb begin
        rf_d  = rf_q + RW'(1);
        dig_d = dig_q;
        if (rf_q == RW'(REFRESH_CYCLES - 1)) begin
            rf_d  = '0;
            dig_d = dig_q + 3'd1;
        end
        case (mode_q)
            ALM_SET:   begin p2 = {2'b0, al_q.hr}; p1 = {1'b0, al_q.mn}; p0 = {1'b0, al_q.sc}; end
            STOPWATCH: begin p2 = {1'b0, mm_q};    p1 = {1'b0, ss_q};    p0 = cs_q;            end
            default:   begin p2 = {2'b0, tm_q.hr}; p1 = {1'b0, tm_q.mn}; p0 = {1'b0, tm_q.sc}; end
        endcase
        case (dig_q)
            3'd0:    digit = 4'(p0 % 7'd10);
            3'd1:    digit = 4'(p0 / 7'd10);
            3'd2:    digit = 4'(p1 % 7'd10);
            3'd3:    digit = 4'(p1 / 7'd10);
            3'd4:    digit = 4'(p2 % 7'd10);
            3'd5:    digit = 4'(p2 / 7'd10);
            default: digit = DIGIT_BLANK;
        endcase
        an_d  = ~(8'b1 << dig_q);
        seg_d = ~{(dig_q == 3'd2 || dig_q == 3'd4), seg_decode(digit)};
    end

    always_comb begin
        led        = '0;
        led[2:0]   = (in_clk || in_alm) ? (3'b001 << cur_q) : 3'b000;
        led[12]    = in_sw;
        led[13]    = in_alm;
        led[14]    = sw_run_q;
        led[15]    = ring_q;
    end

    always_ff @(posedge MCLK or posedge rst) begin
        if (rst) begin
            mode_q   <= NORMAL;
            pre_q    <= '0;
            tm_q     <= '0;
            al_q     <= '0;
            cur_q    <= F_SEC;
            ring_q   <= 1'b0;
            rsec_q   <= '0;
            tone_q   <= '0;
            piezo_q  <= 1'b0;
            sw_run_q <= 1'b0;
            swp_q    <= '0;
            cs_q     <= '0;
            ss_q     <= '0;
            mm_q     <= '0;
            rf_q     <= '0;
            dig_q    <= '0;
            seg_q    <= 8'hFF;
            an_q     <= 8'hFE;
        end else begin
            mode_q   <= mode_d;
            pre_q    <= pre_d;
            tm_q     <= tm_d;
            al_q     <= al_d;
            cur_q    <= cur_d;
            ring_q   <= ring_d;
            rsec_q   <= rsec_d;
            tone_q   <= tone_d;
            piezo_q  <= piezo_d;
            sw_run_q <= sw_run_d;
            swp_q    <= swp_d;
            cs_q     <= cs_d;
            ss_q     <= ss_d;
            mm_q     <= mm_d;
            rf_q     <= rf_d;
            dig_q    <= dig_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
        end
    end

    assign seg_n = seg_q;
    assign an_n  = an_q;
    assign piezo = piezo_q;

endmodule

// File: tb/tb_mfc_top.sv
// Directed walk through reset, clock set, rollover, alarm and stopwatch with
// randomized edit counts and run lengths, checked against a simple time model.
module tb_mfc_top;
    localparam int TPS    = 1000;
    localparam int DEB    = 16;
    localparam int REF    = 4;
    localparam int TONE   = 25;
    localparam int CS_DIV = TPS / 100;
    localparam int HOLD   = DEB + 6;

    logic        MCLK = 1'b0;
    logic [14:0] SPDT;
    logic [4:0]  button;
    logic [7:0]  seg_n, an_n;
    logic [15:0] led;
    logic        piezo;

    int cyc = 0;
    int t0 = 0;
    int total = 0;
    int passed = 0;

    mfc_top #(.TICKS_PER_SEC(TPS), .DEBOUNCE_CYCLES(DEB), .REFRESH_CYCLES(REF), .TONE_DIV(TONE)) dut (
        .MCLK(MCLK), .SPDT(SPDT), .button(button),
        .seg_n(seg_n), .an_n(an_n), .led(led), .piezo(piezo)
    );

    always #5 MCLK = ~MCLK;
    always @(posedge MCLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] bcd6(input int a, input int b, input int c);
        return {4'(a / 10), 4'(a % 10), 4'(b / 10), 4'(b % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    function automatic logic [3:0] seg2dig(input logic [6:0] s);
        case (s)
            7'h3F: return 4'd0;
            7'h06: return 4'd1;
            7'h5B: return 4'd2;
            7'h4F: return 4'd3;
            7'h66: return 4'd4;
            7'h6D: return 4'd5;
            7'h7D: return 4'd6;
            7'h07: return 4'd7;
            7'h7F: return 4'd8;
            7'h6F: return 4'd9;
            7'h00: return 4'hF;
            default: return 4'hE;
        endcase
    endfunction

    // Scan the multiplexed display for two full rounds and reassemble digits 5..0.
    task automatic read_disp(output logic [23:0] val, output logic ok);
        logic [3:0] d[8];
        logic       seen[8];
        ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            d[i] = 4'hE;
            seen[i] = 1'b0;
        end
        repeat (16 * REF) begin
            int k;
            @(negedge MCLK);
            k = -1;
            for (int i = 0; i < 8; i++) if (an_n == ~(8'b1 << i)) k = i;
            if (k < 0) begin
                ok = 1'b0;
            end else begin
                seen[k] = 1'b1;
                d[k] = seg2dig(~seg_n[6:0]);
                if (seg_n[7] != !(k == 2 || k == 4)) ok = 1'b0;
            end
        end
        for (int i = 0; i < 8; i++) if (!seen[i]) ok = 1'b0;
        if (d[7] != 4'hF || d[6] != 4'hF) ok = 1'b0;
        val = {d[5], d[4], d[3], d[2], d[1], d[0]};
    endtask

    task automatic show(input string tag, input logic [23:0] exp);
        logic [23:0] v;
        logic        ok;
        read_disp(v, ok);
        check(tag, {8'h0, v}, {8'h0, exp});
        check({tag, "_fmt"}, {31'h0, ok}, 32'h1);
    endtask

    task automatic press(input int b);
        @(negedge MCLK);
        button[b] = 1'b1;
        repeat (HOLD) @(negedge MCLK);
        button[b] = 1'b0;
        repeat (HOLD) @(negedge MCLK);
    endtask

    // Middle of second k after the last prescaler restart, well clear of any tick.
    task automatic wait_at(input int k);
        while ((cyc - t0) < k * TPS + TPS / 2) @(negedge MCLK);
    endtask

    task automatic sw_run(input int n, input bit try_clear);
        int ts;
        @(negedge MCLK);
        ts = cyc;
        button[4] = 1'b1;
        repeat (HOLD) @(negedge MCLK);
        button[4] = 1'b0;
        repeat (HOLD) @(negedge MCLK);
        check("sw_running_led", {31'h0, led[14]}, 32'h1);
        if (try_clear) press(1);
        while (cyc - ts < CS_DIV * n + CS_DIV / 2) @(negedge MCLK);
        button[4] = 1'b1;
        repeat (HOLD) @(negedge MCLK);
        button[4] = 1'b0;
        repeat (HOLD) @(negedge MCLK);
        check("sw_stopped_led", {31'h0, led[14]}, 32'h0);
    endtask

    initial begin
        int hh, mm, ss, k, a, n1, n2, tot, p, cnt;
        SPDT   = 15'h0001;
        button = '0;
        repeat (50) @(negedge MCLK);
        check("rst_an_n", {24'h0, an_n}, 32'hFE);
        check("rst_seg_n", {24'h0, seg_n}, 32'hFF);
        check("rst_led", {16'h0, led}, 32'h0);
        check("rst_piezo", {31'h0, piezo}, 32'h0);

        SPDT[0] = 1'b0;
        t0 = cyc;
        wait_at(5);
        show("tod_5s", bcd6(0, 0, 5));

        // Clock set: bouncy up press, then field edits with wraparound.
        SPDT[14] = 1'b1;
        repeat (2) @(negedge MCLK);
        check("cursor_sec", {29'h0, led[2:0]}, 32'h1);
        repeat (50) begin
            @(negedge MCLK);
            button[0] = ~button[0];
        end
        press(0);
        hh = 0; mm = 0; ss = 6;
        show("bounce_once", bcd6(hh, mm, ss));
        repeat (3 * TPS) @(negedge MCLK);
        show("frozen", bcd6(hh, mm, ss));
        k = $urandom_range(1, 4);
        repeat (k) press(0);
        ss = ss + k;
        press(3);
        check("cursor_hr", {29'h0, led[2:0]}, 32'h4);
        press(1);
        hh = 23;
        show("hr_down_wrap", bcd6(hh, mm, ss));
        press(2);
        press(2);
        check("cursor_min", {29'h0, led[2:0]}, 32'h2);
        press(1);
        mm = 59;
        show("min_down_wrap", bcd6(hh, mm, ss));
        press(0);
        mm = 0;
        show("min_up_wrap", bcd6(hh, mm, ss));
        press(1);
        mm = 59;
        press(3);
        repeat (ss + 1) press(1);
        ss = 59;
        show("set_235959", bcd6(hh, mm, ss));

        SPDT[14] = 1'b0;
        t0 = cyc;
        wait_at(0);
        show("resume_235959", bcd6(23, 59, 59));
        wait_at(1);
        show("rollover", bcd6(0, 0, 0));

        // Alarm set while time keeps running, then ring and acknowledge.
        SPDT[13] = 1'b1;
        repeat (2) @(negedge MCLK);
        check("alm_led", {31'h0, led[13]}, 32'h1);
        a = $urandom_range(3, 5);
        repeat (a) press(0);
        show("alarm_disp", bcd6(0, 0, a));
        SPDT[13] = 1'b0;
        SPDT[1]  = 1'b1;
        wait_at(a);
        show("time_ran_in_alm", bcd6(0, 0, a - 1));
        check("no_ring_early", {31'h0, led[15]}, 32'h0);
        wait_at(a + 1);
        check("ring_on", {31'h0, led[15]}, 32'h1);
        p = piezo;
        cnt = 0;
        while (piezo == p && cnt < 4 * TONE) begin
            @(negedge MCLK);
            cnt++;
        end
        p = piezo;
        cnt = 0;
        while (piezo == p && cnt < 4 * TONE) begin
            @(negedge MCLK);
            cnt++;
        end
        check("tone_half_period", cnt, TONE);
        press(4);
        check("ring_ack", {31'h0, led[15]}, 32'h0);
        check("piezo_off", {31'h0, piezo}, 32'h0);

        // Stopwatch: two timed runs, clear ignored while running, clear when stopped.
        SPDT[12] = 1'b1;
        repeat (2) @(negedge MCLK);
        check("sw_led", {31'h0, led[12]}, 32'h1);
        show("sw_zero", bcd6(0, 0, 0));
        n1 = $urandom_range(30, 150);
        sw_run(n1, 1'b0);
        tot = n1;
        show("sw_run1", bcd6(tot / 6000, (tot / 100) % 60, tot % 100));
        n2 = $urandom_range(30, 150);
        sw_run(n2, 1'b1);
        tot = tot + n2;
        show("sw_run2", bcd6(tot / 6000, (tot / 100) % 60, tot % 100));
        press(1);
        show("sw_cleared", bcd6(0, 0, 0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
